reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised ARM-style register file with an integrated per-register write scoreboard, sitting between the ID stage (reads, issue) and the WB stage (writes). It provides two asynchronous read ports, one synchronous write port, and hazard flags derived from per-register pending-write counters. The ID-stage stall logic consumes these flags directly instead of comparing destination fields pipeline-wide.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 16, number of architectural registers (power of two, ≥2)
- CNT_W, 2, pending-write counter width per register (max in-flight writes = 2^CNT_W−1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- src1, src2  in  $clog2(NUM_REGS)  read addresses
- src1_used, src2_used  in  1  operand actually consumed this cycle
- reg1, reg2  out  DATA_W  read data
- hazard1, hazard2  out  1  operand not yet valid; ID must stall
- issue_en  in  1  instruction with a register destination leaves ID
- issue_dst  in  $clog2(NUM_REGS)  its destination
- issue_full  out  1  cnt[issue_dst] at max; issue must not be asserted
- wb_en  in  1  writeback valid
- wb_dst  in  $clog2(NUM_REGS)  writeback destination
- wb_data  in  DATA_W  writeback value
- any_pending  out  1  OR of all busy bits

## Operation
- Storage: NUM_REGS × DATA_W, all zero after reset.
- Write: on rising edge with wb_en, regs[wb_dst] ← wb_data. No register is hard-wired.
- Read: reg1/reg2 combinational from src1/src2, full DATA_W (no truncation).
- Scoreboard: counter cnt[r] (CNT_W bits) per register; busy[r] = (cnt[r] ≠ 0).
  - issue_en only: cnt[issue_dst] += 1.
  - wb_en only: cnt[wb_dst] −= 1.
  - Both, same register: cnt unchanged.
  - Both, different registers: each updated independently.
  - issue_en while issue_full: counter saturates (no wrap); it is a protocol violation flagged by assertion.
  - wb_en with cnt[wb_dst] = 0: data is written; counter stays 0 (no underflow). It is a protocol violation flagged by assertion.
- hazard_n = src_n_used & (cnt[src_n] > fwd_n), where fwd_n = 1 when bypass applies (see Configuration), else 0.
- An unused source never raises a hazard.
- issue_full = (cnt[issue_dst] == 2^CNT_W−1), combinational.

## Timing
- Write latency: one edge. The value is readable on reg1/reg2 the cycle after wb_en, or the same cycle with bypass.
- Scoreboard update latency: one edge. An issue in cycle t raises hazard for readers from cycle t+1.
- Outputs reg1, reg2, hazard1, hazard2, issue_full, any_pending are combinational.
- Reset values (the cycle after the rst edge): reg1 = reg2 = 0, hazard1 = hazard2 = 0, issue_full = 0, any_pending = 0.
- rst asserted mid-operation wins over same-cycle wb_en/issue_en: all data and counters clear, and the write is dropped.

## Configuration
- Macro REG_FILE_SB_BYPASS_EN.
- Defined: when wb_en and wb_dst == src_n, reg_n = wb_data in the same cycle, and fwd_n = 1, so a single outstanding write being retired this cycle does not stall the reader.
- Undefined: reg_n always reads storage, fwd_n = 0, and the reader stalls one extra cycle.
- Write behaviour is identical in both builds.

## Structure
- Shared package reg_file_sb_pkg:
  - ADDR_W as $clog2(NUM_REGS) helper function.
  - Counter max constant function.
  - Named register indices: REG_SP = 13, REG_LR = 14, REG_PC = 15.
- One sub-module: sb_counter (CNT_W saturating up/down counter with inc, dec, busy, full), instantiated NUM_REGS times via generate.
- Data array and read muxes stay in the top module.

## Test plan
- Reset: write 0xDEADBEEF to r3, then pulse rst. Required: reg1 reads r3 = 0 and any_pending = 0.
- Basic write/read: wb_en, wb_dst = 5, wb_data = 0x12345678. Required: next cycle src1 = 5 gives reg1 = 0x12345678; src2 = 4 gives reg2 = 0.
- Hazard lifecycle: issue r7, then src1 = 7 with src1_used. Required: hazard1 = 1 until wb to r7. With src1_used = 0: hazard1 = 0.
- Double in-flight: issue r2 twice, then wb r2 once. Required: hazard on r2 persists. After the second wb: cleared. With CNT_W = 2, a third issue gives issue_full = 1.
- Simultaneous issue and wb to r9 with cnt = 1. Required: cnt stays 1 and hazard on r9 is unchanged.
- Bypass build: wb r4 = 0xA5A5A5A5 with src2 = 4, src2_used, cnt[4] = 1. Required: same cycle reg2 = 0xA5A5A5A5 and hazard2 = 0. Non-bypass build: reg2 shows old value and hazard2 = 1.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package reg_file_sb_pkg;

   // Named architectural register indices.
   localparam int unsigned REG_SP = 13;
   localparam int unsigned REG_LR = 14;
   localparam int unsigned REG_PC = 15;

   // Per-register scoreboard counter operation for one cycle.
   typedef enum logic [1:0] {
      SB_HOLD = 2'd0,
      SB_INC  = 2'd1,
      SB_DEC  = 2'd2
   } sb_op_e;

   // Register address width for a given register count.
   function automatic int unsigned addr_w(input int unsigned num_regs);
      return (num_regs < 2) ? 1 : $clog2(num_regs);
   endfunction

   // Largest value a cnt_w-bit pending-write counter can hold.
   function automatic int unsigned cnt_max(input int unsigned cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down pending-write counter for one register.
// Simultaneous inc and dec cancel; inc at max and dec at zero are held.
module sb_counter
   import reg_file_sb_pkg::*;
#(
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             busy,
   output logic             full
);

   localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

   sb_op_e op;

   // Busy/full flags are read combinationally by the ID stage.
   assign busy = (cnt != '0);
   assign full = (cnt == MAX);

   // Resolve this cycle's counter operation with saturation at both ends.
   always_comb begin
      op = SB_HOLD;
      if (inc && !dec && !full)
         op = SB_INC;
      else if (dec && !inc && busy)
         op = SB_DEC;
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         case (op)
            SB_INC:  cnt <= cnt + CNT_W'(1);
            SB_DEC:  cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two async read ports, one sync write port and a
// per-register pending-write scoreboard producing ID-stage hazard flags.
// Optional macro REG_FILE_SB_BYPASS_EN forwards the retiring writeback to
// the read ports in the same cycle and lets it satisfy one pending write.
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned CNT_W    = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [addr_w(NUM_REGS)-1:0]   src1,
   input  logic [addr_w(NUM_REGS)-1:0]   src2,
   input  logic                          src1_used,
   input  logic                          src2_used,
   output logic [DATA_W-1:0]             reg1,
   output logic [DATA_W-1:0]             reg2,
   output logic                          hazard1,
   output logic                          hazard2,
   input  logic                          issue_en,
   input  logic [addr_w(NUM_REGS)-1:0]   issue_dst,
   output logic                          issue_full,
   input  logic                          wb_en,
   input  logic [addr_w(NUM_REGS)-1:0]   wb_dst,
   input  logic [DATA_W-1:0]             wb_data,
   output logic                          any_pending
);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [CNT_W-1:0]    cnt  [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] full;
   logic [NUM_REGS-1:0] inc;
   logic [NUM_REGS-1:0] dec;
   logic                fwd1;
   logic                fwd2;

   // Decode issue and writeback into one-hot counter strobes.
   always_comb begin
      inc            = '0;
      dec            = '0;
      inc[issue_dst] = issue_en;
      dec[wb_dst]    = wb_en;
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
      sb_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk  (clk),
         .rst  (rst),
         .inc  (inc[i]),
         .dec  (dec[i]),
         .cnt  (cnt[i]),
         .busy (busy[i]),
         .full (full[i])
      );
   end

   // Data array: reset clears everything and drops a same-cycle write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (wb_en) begin
         regs[wb_dst] <= wb_data;
      end
   end

`ifdef REG_FILE_SB_BYPASS_EN
   // Read muxes with same-cycle writeback forwarding.
   always_comb begin
      fwd1 = wb_en && (wb_dst == src1);
      fwd2 = wb_en && (wb_dst == src2);
      reg1 = fwd1 ? wb_data : regs[src1];
      reg2 = fwd2 ? wb_data : regs[src2];
   end
`else
   // Read muxes straight from storage.
   always_comb begin
      fwd1 = 1'b0;
      fwd2 = 1'b0;
      reg1 = regs[src1];
      reg2 = regs[src2];
   end
`endif

   // A forwarded writeback covers exactly one outstanding write.
   always_comb begin
      hazard1     = src1_used && (cnt[src1] > CNT_W'(fwd1));
      hazard2     = src2_used && (cnt[src2] > CNT_W'(fwd2));
      issue_full  = full[issue_dst];
      any_pending = |busy;
   end

   a_no_issue_when_full : assert property (
      @(posedge clk) disable iff (rst) !(issue_en && issue_full));

   a_no_wb_when_idle : assert property (
      @(posedge clk) disable iff (rst) !(wb_en && !busy[wb_dst]));

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table, a short hand sequence and
// protocol-legal random traffic checked against a behavioural model.
module tb_reg_file_sb;

`ifdef REG_FILE_SB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  src1, src2, issue_dst, wb_dst;
   logic        src1_used, src2_used, issue_en, wb_en;
   logic [31:0] wb_data;
   logic [31:0] reg1, reg2;
   logic        hazard1, hazard2, issue_full, any_pending;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model: register contents and count of outstanding writes.
   logic [31:0] m_regs [16];
   int          m_cnt  [16];

   typedef struct {
      logic        rst;
      logic        ie;
      logic [3:0]  idst;
      logic        we;
      logic [3:0]  wdst;
      logic [31:0] wdata;
      logic [3:0]  s1;
      logic        u1;
      logic [3:0]  s2;
      logic        u2;
      logic [31:0] r1;
      logic [31:0] r2;
      logic        h1;
      logic        h2;
      logic        full;
      logic        pend;
   } vec_t;

   vec_t tbl [$];

   reg_file_sb dut (
      .clk         (clk),
      .rst         (rst),
      .src1        (src1),
      .src2        (src2),
      .src1_used   (src1_used),
      .src2_used   (src2_used),
      .reg1        (reg1),
      .reg2        (reg2),
      .hazard1     (hazard1),
      .hazard2     (hazard2),
      .issue_en    (issue_en),
      .issue_dst   (issue_dst),
      .issue_full  (issue_full),
      .wb_en       (wb_en),
      .wb_dst      (wb_dst),
      .wb_data     (wb_data),
      .any_pending (any_pending)
   );

   always #5 clk = ~clk;

   function automatic vec_t v(input logic r, ie, input logic [3:0] idst,
                              input logic we, input logic [3:0] wdst,
                              input logic [31:0] wdata,
                              input logic [3:0] s1, input logic u1,
                              input logic [3:0] s2, input logic u2,
                              input logic [31:0] r1, r2,
                              input logic h1, h2, full, pend);
      vec_t t;
      t.rst = r;   t.ie = ie;   t.idst = idst; t.we = we; t.wdst = wdst;
      t.wdata = wdata; t.s1 = s1; t.u1 = u1; t.s2 = s2; t.u2 = u2;
      t.r1 = r1;   t.r2 = r2;   t.h1 = h1;   t.h2 = h2;
      t.full = full; t.pend = pend;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input logic r, ie, input logic [3:0] idst,
                        input logic we, input logic [3:0] wdst,
                        input logic [31:0] wdata,
                        input logic [3:0] s1, input logic u1,
                        input logic [3:0] s2, input logic u2);
      rst = r; issue_en = ie; issue_dst = idst; wb_en = we; wb_dst = wdst;
      wb_data = wdata; src1 = s1; src1_used = u1; src2 = s2; src2_used = u2;
   endtask

   // Advance one clock; the model takes the edge with the driven inputs.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_cnt[i]  = 0;
         end
      end else begin
         if (wb_en) begin
            m_regs[wb_dst] = wb_data;
            m_cnt[wb_dst]  = m_cnt[wb_dst] - 1;
         end
         if (issue_en)
            m_cnt[issue_dst] = m_cnt[issue_dst] + 1;
      end
      #1;
   endtask

   function automatic logic [31:0] m_read(input logic [3:0] s);
      if (BYP && wb_en && wb_dst == s) return wb_data;
      return m_regs[s];
   endfunction

   function automatic logic m_haz(input logic [3:0] s, input logic u);
      int fwd;
      fwd = (BYP && wb_en && wb_dst == s) ? 1 : 0;
      return u && (m_cnt[s] > fwd);
   endfunction

   task automatic chk_model(input string tag);
      int pend;
      pend = 0;
      for (int i = 0; i < 16; i++) if (m_cnt[i] != 0) pend = 1;
      chk({tag, " reg1"}, reg1, m_read(src1));
      chk({tag, " reg2"}, reg2, m_read(src2));
      chk({tag, " hazard1"}, 32'(hazard1), 32'(m_haz(src1, src1_used)));
      chk({tag, " hazard2"}, 32'(hazard2), 32'(m_haz(src2, src2_used)));
      chk({tag, " issue_full"}, 32'(issue_full), 32'(m_cnt[issue_dst] == 3));
      chk({tag, " any_pending"}, 32'(any_pending), 32'(pend));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         m_regs[i] = '0;
         m_cnt[i]  = 0;
      end

      // Directed table: outputs expected in the cycle the inputs are applied.
      tbl.push_back(v(0,1,3, 0,0,0,             3,1,0,0, 0,0, 0,0,0,0));
      tbl.push_back(v(0,0,0, 1,3,32'hDEADBEEF,  3,1,0,0, BYP ? 32'hDEADBEEF : 32'h0,0, !BYP,0,0,1));
      tbl.push_back(v(0,0,0, 0,0,0,             3,1,0,0, 32'hDEADBEEF,0, 0,0,0,0));
      tbl.push_back(v(1,0,0, 0,0,0,             3,1,0,0, 32'hDEADBEEF,0, 0,0,0,0));
      tbl.push_back(v(0,0,0, 0,0,0,             3,1,0,0, 0,0, 0,0,0,0));
      tbl.push_back(v(0,1,1, 0,0,0,             1,0,0,0, 0,0, 0,0,0,0));
      tbl.push_back(v(1,0,0, 1,1,32'h1111,      1,0,0,0, BYP ? 32'h1111 : 32'h0,0, 0,0,0,1));
      tbl.push_back(v(0,0,0, 0,0,0,             1,1,0,0, 0,0, 0,0,0,0));
      tbl.push_back(v(0,1,5, 0,0,0,             5,1,0,0, 0,0, 0,0,0,0));
      tbl.push_back(v(0,0,0, 1,5,32'h12345678,  5,0,4,1, BYP ? 32'h12345678 : 32'h0,0, 0,0,0,1));
      tbl.push_back(v(0,0,0, 0,0,0,             5,1,4,1, 32'h12345678,0, 0,0,0,0));
      tbl.push_back(v(0,1,7, 0,0,0,             7,1,0,0, 0,0, 0,0,0,0));
      tbl.push_back(v(0,0,0, 0,0,0,             7,1,0,0, 0,0, 1,0,0,1));
      tbl.push_back(v(0,0,0, 0,0,0,             7,0,0,0, 0,0, 0,0,0,1));
      tbl.push_back(v(0,0,0, 1,7,32'h77,        7,1,0,0, BYP ? 32'h77 : 32'h0,0, !BYP,0,0,1));
      tbl.push_back(v(0,0,0, 0,0,0,             7,1,0,0, 32'h77,0, 0,0,0,0));
      tbl.push_back(v(0,1,2, 0,0,0,             2,1,0,0, 0,0, 0,0,0,0));
      tbl.push_back(v(0,1,2, 0,0,0,             2,1,0,0, 0,0, 1,0,0,1));
      tbl.push_back(v(0,0,2, 1,2,32'h22,        2,1,0,0, BYP ? 32'h22 : 32'h0,0, 1,0,0,1));
      tbl.push_back(v(0,0,2, 0,0,0,             2,1,0,0, 32'h22,0, 1,0,0,1));
      tbl.push_back(v(0,0,2, 1,2,32'h23,        2,1,0,0, BYP ? 32'h23 : 32'h22,0, !BYP,0,0,1));
      tbl.push_back(v(0,0,2, 0,0,0,             2,1,0,0, 32'h23,0, 0,0,0,0));
      tbl.push_back(v(0,1,2, 0,0,0,             2,0,0,0, 32'h23,0, 0,0,0,0));
      tbl.push_back(v(0,1,2, 0,0,0,             2,0,0,0, 32'h23,0, 0,0,0,1));
      tbl.push_back(v(0,1,2, 0,0,0,             2,0,0,0, 32'h23,0, 0,0,0,1));
      tbl.push_back(v(0,0,2, 0,0,0,             2,1,0,0, 32'h23,0, 1,0,1,1));
      tbl.push_back(v(0,0,2, 1,2,32'h24,        2,1,0,0, BYP ? 32'h24 : 32'h23,0, 1,0,1,1));
      tbl.push_back(v(0,0,2, 1,2,32'h25,        2,1,0,0, BYP ? 32'h25 : 32'h24,0, 1,0,0,1));
      tbl.push_back(v(0,0,2, 1,2,32'h26,        2,1,0,0, BYP ? 32'h26 : 32'h25,0, !BYP,0,0,1));
      tbl.push_back(v(0,0,2, 0,0,0,             2,1,0,0, 32'h26,0, 0,0,0,0));
      tbl.push_back(v(0,1,9, 0,0,0,             9,1,0,0, 0,0, 0,0,0,0));
      tbl.push_back(v(0,1,9, 1,9,32'h99,        9,1,0,0, BYP ? 32'h99 : 32'h0,0, !BYP,0,0,1));
      tbl.push_back(v(0,0,9, 0,0,0,             9,1,0,0, 32'h99,0, 1,0,0,1));
      tbl.push_back(v(0,0,0, 1,9,32'h9A,        9,0,0,0, BYP ? 32'h9A : 32'h99,0, 0,0,0,1));
      tbl.push_back(v(0,0,0, 0,0,0,             9,1,0,0, 32'h9A,0, 0,0,0,0));
      tbl.push_back(v(0,1,4, 0,0,0,             0,0,4,1, 0,0, 0,0,0,0));
      tbl.push_back(v(0,0,0, 1,4,32'hA5A5A5A5,  0,0,4,1, 0,BYP ? 32'hA5A5A5A5 : 32'h0, 0,!BYP,0,1));
      tbl.push_back(v(0,0,0, 0,0,0,             0,0,4,1, 0,32'hA5A5A5A5, 0,0,0,0));
      tbl.push_back(v(0,1,8, 0,0,0,             10,1,8,1, 0,0, 0,0,0,0));
      tbl.push_back(v(0,1,10, 1,8,32'h88,       10,1,8,1, 0,BYP ? 32'h88 : 32'h0, 0,!BYP,0,1));
      tbl.push_back(v(0,0,0, 0,0,0,             10,1,8,1, 0,32'h88, 1,0,0,1));
      tbl.push_back(v(0,0,0, 1,10,32'hAA,       10,1,8,1, BYP ? 32'hAA : 32'h0,32'h88, !BYP,0,0,1));
      tbl.push_back(v(0,0,0, 0,0,0,             10,1,8,1, 32'hAA,32'h88, 0,0,0,0));

      // Power-on reset.
      drive(1,0,0, 0,0,0, 0,0,0,0);
      tick();
      tick();

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].ie, tbl[i].idst, tbl[i].we, tbl[i].wdst,
               tbl[i].wdata, tbl[i].s1, tbl[i].u1, tbl[i].s2, tbl[i].u2);
         @(negedge clk);
         chk($sformatf("vec%0d reg1", i), reg1, tbl[i].r1);
         chk($sformatf("vec%0d reg2", i), reg2, tbl[i].r2);
         chk($sformatf("vec%0d hazard1", i), 32'(hazard1), 32'(tbl[i].h1));
         chk($sformatf("vec%0d hazard2", i), 32'(hazard2), 32'(tbl[i].h2));
         chk($sformatf("vec%0d issue_full", i), 32'(issue_full), 32'(tbl[i].full));
         chk($sformatf("vec%0d any_pending", i), 32'(any_pending), 32'(tbl[i].pend));
         tick();
      end

      // Hand sequence: PC written and read on both ports at once.
      drive(0,1,4'd15, 0,0,0, 4'd15,1,4'd15,1);
      tick();
      drive(0,0,0, 1,4'd15,32'hCAFEF00D, 4'd15,1,4'd15,1);
      @(negedge clk);
      chk("pc hazard1 at wb", 32'(hazard1), 32'(!BYP));
      chk("pc hazard2 at wb", 32'(hazard2), 32'(!BYP));
      chk("pc reg2 at wb", reg2, BYP ? 32'hCAFEF00D : 32'h0);
      tick();
      drive(0,0,0, 0,0,0, 4'd15,1,4'd15,1);
      @(negedge clk);
      chk("pc reg1 after wb", reg1, 32'hCAFEF00D);
      chk("pc reg2 after wb", reg2, 32'hCAFEF00D);
      chk("pc hazard1 after wb", 32'(hazard1), 32'h0);
      tick();

      // Random protocol-legal traffic against the model.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic       r, ie, we;
         logic [3:0] idst, wdst;
         int         off;
         r    = ($urandom_range(0, 249) == 0);
         idst = 4'($urandom_range(0, 15));
         ie   = ($urandom_range(0, 2) != 0) && (m_cnt[idst] < 3);
         off  = $urandom_range(0, 15);
         we   = 1'b0;
         wdst = 4'(off);
         if ($urandom_range(0, 2) != 0) begin
            for (int k = 0; k < 16; k++) begin
               if (!we && m_cnt[(off + k) % 16] > 0) begin
                  we   = 1'b1;
                  wdst = 4'((off + k) % 16);
               end
            end
         end
         drive(r, ie, idst, we, wdst, $urandom,
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) src1 = wdst;
         if ($urandom_range(0, 3) == 0) src2 = idst;
         @(negedge clk);
         chk_model($sformatf("rnd%0d", cyc));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
